// File: rtl/cjb_8bit_alu_wb_stage_v.sv
// Writeback stage behind the 8-bit ALU. It holds up to two results until the
// register file takes them, keeps the status flags, and evaluates branch conditions.
module cjb_8bit_alu_wb_stage_v #(
  parameter int DEST_W = 3
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [7:0]        ALU_Result,
  input  logic [3:0]        ALU_CNVZ,
  input  logic [DEST_W-1:0] Dest_Addr,
  input  logic              Flag_WE,
  input  logic              Flush,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [7:0]        WB_Data,
  output logic [DEST_W-1:0] WB_Dest,
  output logic [3:0]        PSR_CNVZ,
  input  logic [2:0]        Cond_Sel,
  output logic              Cond_True,
  output logic              Carry_Out,
  output logic [1:0]        state_dbg
);

  // Handshake: a transfer happens on any rising edge where valid and ready
  // are both 1; valid never waits on ready, and ready depends only on
  // registered state and Flush.

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  logic              wr_ptr;
  logic              rd_ptr;
  logic [7:0]        data_mem [2];
  logic [DEST_W-1:0] dest_mem [2];
  logic              push;
  logic              pop;

  assign In_Ready  = (state != FULL) && !Flush;
  assign Out_Valid = (state != EMPTY);
  assign push      = In_Valid && In_Ready;
  assign pop       = Out_Valid && Out_Ready;
  assign state_dbg = state;
  assign Carry_Out = PSR_CNVZ[3];

  // Stale entries are masked so nothing leaks out while the buffer is empty.
  assign WB_Data = Out_Valid ? data_mem[rd_ptr] : 8'd0;
  assign WB_Dest = Out_Valid ? dest_mem[rd_ptr] : '0;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= EMPTY;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      PSR_CNVZ <= 4'b0000;
    end else if (Flush) begin
      state  <= EMPTY;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
        if (Flag_WE) PSR_CNVZ <= ALU_CNVZ;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case (state)
        EMPTY: if (push) state <= ONE;
        ONE: begin
          if (push && !pop)      state <= FULL;
          else if (pop && !push) state <= EMPTY;
        end
        FULL:    if (pop) state <= ONE;
        default: state <= EMPTY;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (push) begin
      data_mem[wr_ptr] <= ALU_Result;
      dest_mem[wr_ptr] <= Dest_Addr;
    end
  end

  always_comb begin
    Cond_True = 1'b1;
    case (Cond_Sel)
      3'b000: Cond_True = 1'b1;
      3'b001: Cond_True = PSR_CNVZ[3];
      3'b010: Cond_True = PSR_CNVZ[2];
      3'b011: Cond_True = PSR_CNVZ[1];
      3'b100: Cond_True = PSR_CNVZ[0];
      3'b101: Cond_True = ~PSR_CNVZ[3];
      3'b110: Cond_True = ~PSR_CNVZ[0];
      3'b111: Cond_True = PSR_CNVZ[2] ^ PSR_CNVZ[1];
      default: Cond_True = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_cjb_8bit_alu_wb_stage_v.sv
// Bench for the ALU writeback stage: directed scenarios followed by random traffic,
// compared every cycle against a queue-based model of the buffer and the flag register.
module tb_cjb_8bit_alu_wb_stage_v;
  localparam int DEST_W = 3;
  localparam int W = 8 + DEST_W;

  logic              Clock;
  logic              Reset;
  logic              In_Valid;
  logic              In_Ready;
  logic [7:0]        ALU_Result;
  logic [3:0]        ALU_CNVZ;
  logic [DEST_W-1:0] Dest_Addr;
  logic              Flag_WE;
  logic              Flush;
  logic              Out_Valid;
  logic              Out_Ready;
  logic [7:0]        WB_Data;
  logic [DEST_W-1:0] WB_Dest;
  logic [3:0]        PSR_CNVZ;
  logic [2:0]        Cond_Sel;
  logic              Cond_True;
  logic              Carry_Out;
  logic [1:0]        state_dbg;

  cjb_8bit_alu_wb_stage_v #(.DEST_W(DEST_W)) dut (
    .Clock(Clock), .Reset(Reset), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .ALU_Result(ALU_Result), .ALU_CNVZ(ALU_CNVZ), .Dest_Addr(Dest_Addr),
    .Flag_WE(Flag_WE), .Flush(Flush), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
    .WB_Data(WB_Data), .WB_Dest(WB_Dest), .PSR_CNVZ(PSR_CNVZ), .Cond_Sel(Cond_Sel),
    .Cond_True(Cond_True), .Carry_Out(Carry_Out), .state_dbg(state_dbg)
  );

  // clock / reset
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // scoreboard: entries are {dest, data}, oldest at the front
  logic [W-1:0] exp_q[$];
  logic [3:0]   exp_psr;
  int           checks = 0;
  int           errors = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic cond_model(input logic [3:0] psr, input logic [2:0] sel);
    int c, n, v, z;
    c = psr[3]; n = psr[2]; v = psr[1]; z = psr[0];
    case (sel)
      3'd0: return 1'b1;
      3'd1: return c == 1;
      3'd2: return n == 1;
      3'd3: return v == 1;
      3'd4: return z == 1;
      3'd5: return c == 0;
      3'd6: return z == 0;
      default: return n != v;
    endcase
  endfunction

  task automatic check_outputs();
    logic [W-1:0] head;
    int sz;
    sz = exp_q.size();
    head = (sz > 0) ? exp_q[0] : '0;
    chk("in_ready", 16'(In_Ready), 16'((sz < 2) && !Flush));
    chk("out_valid", 16'(Out_Valid), 16'(sz > 0));
    chk("state", 16'(state_dbg), 16'(sz));
    chk("wb_data", 16'(WB_Data), 16'(head[7:0]));
    chk("wb_dest", 16'(WB_Dest), 16'(head[W-1:8]));
    chk("psr", 16'(PSR_CNVZ), 16'(exp_psr));
    chk("carry_out", 16'(Carry_Out), 16'(exp_psr[3]));
    chk("cond_true", 16'(Cond_True), 16'(cond_model(exp_psr, Cond_Sel)));
  endtask

  // driver: called at a falling edge, applies inputs for one full cycle
  task automatic drive(input logic v, input logic [7:0] data, input logic [DEST_W-1:0] dest,
                       input logic fwe, input logic [3:0] cnvz, input logic ordy,
                       input logic fl, input logic [2:0] sel);
    logic do_push, do_pop;
    In_Valid = v; ALU_Result = data; Dest_Addr = dest; Flag_WE = fwe;
    ALU_CNVZ = cnvz; Out_Ready = ordy; Flush = fl; Cond_Sel = sel;
    #1;
    check_outputs();
    do_push = v && !fl && (exp_q.size() < 2);
    do_pop  = ordy && (exp_q.size() > 0);
    @(posedge Clock);
    if (fl) begin
      exp_q.delete();
    end else begin
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) begin
        exp_q.push_back({dest, data});
        if (fwe) exp_psr = cnvz;
      end
    end
    @(negedge Clock);
  endtask

  task automatic idle(input logic ordy, input logic [2:0] sel);
    drive(1'b0, 8'h00, '0, 1'b0, 4'h0, ordy, 1'b0, sel);
  endtask

  initial begin
    Reset = 1'b1; In_Valid = 0; ALU_Result = 0; ALU_CNVZ = 0; Dest_Addr = 0;
    Flag_WE = 0; Flush = 0; Out_Ready = 0; Cond_Sel = 0;
    exp_psr = 4'h0;
    @(negedge Clock);
    chk("reset_in_ready", 16'(In_Ready), 16'd1);
    chk("reset_out_valid", 16'(Out_Valid), 16'd0);
    chk("reset_psr", 16'(PSR_CNVZ), 16'd0);
    chk("reset_wb_data", 16'(WB_Data), 16'd0);
    Reset = 1'b0;

    // single push with flag write
    drive(1'b1, 8'h5A, 3'd3, 1'b1, 4'b1001, 1'b1, 1'b0, 3'd1);
    idle(1'b1, 3'd5);
    idle(1'b1, 3'd0);

    // backpressure: fill, refused third push, then drain in order
    drive(1'b1, 8'h11, 3'd1, 1'b0, 4'h0, 1'b0, 1'b0, 3'd0);
    drive(1'b1, 8'h22, 3'd2, 1'b0, 4'h0, 1'b0, 1'b0, 3'd0);
    drive(1'b1, 8'h33, 3'd3, 1'b1, 4'b0110, 1'b0, 1'b0, 3'd0);
    idle(1'b0, 3'd2);
    idle(1'b1, 3'd2);
    idle(1'b1, 3'd2);
    idle(1'b1, 3'd2);

    // simultaneous push and pop while holding one entry
    drive(1'b1, 8'h11, 3'd1, 1'b0, 4'h0, 1'b0, 1'b0, 3'd0);
    drive(1'b1, 8'h44, 3'd4, 1'b0, 4'h0, 1'b1, 1'b0, 3'd0);
    idle(1'b1, 3'd0);

    // flag write enable and the condition table
    drive(1'b1, 8'h01, 3'd0, 1'b0, 4'b1111, 1'b1, 1'b0, 3'd0);
    drive(1'b1, 8'h02, 3'd0, 1'b1, 4'b0100, 1'b1, 1'b0, 3'd7);
    for (int s = 0; s < 8; s++) idle(1'b1, 3'(s));
    drive(1'b1, 8'h03, 3'd0, 1'b1, 4'b0010, 1'b1, 1'b0, 3'd0);
    for (int s = 0; s < 8; s++) idle(1'b1, 3'(s));

    // flush from FULL with a push attempt that must be dropped
    drive(1'b1, 8'hA1, 3'd5, 1'b0, 4'h0, 1'b0, 1'b0, 3'd0);
    drive(1'b1, 8'hA2, 3'd6, 1'b0, 4'h0, 1'b0, 1'b0, 3'd0);
    drive(1'b1, 8'hA3, 3'd7, 1'b1, 4'b1111, 1'b0, 1'b1, 3'd0);
    idle(1'b1, 3'd4);
    idle(1'b1, 3'd4);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0),
            3'($urandom_range(0, 7)));
    end

    // asynchronous reset in the middle of a stream
    drive(1'b1, 8'hC1, 3'd1, 1'b1, 4'b1011, 1'b0, 1'b0, 3'd0);
    drive(1'b1, 8'hC2, 3'd2, 1'b1, 4'b1101, 1'b0, 1'b0, 3'd0);
    In_Valid = 1'b0; Flag_WE = 1'b0; Out_Ready = 1'b0;
    #2;
    Reset = 1'b1;
    #1;
    chk("async_out_valid", 16'(Out_Valid), 16'd0);
    chk("async_psr", 16'(PSR_CNVZ), 16'd0);
    chk("async_wb_data", 16'(WB_Data), 16'd0);
    chk("async_wb_dest", 16'(WB_Dest), 16'd0);
    chk("async_in_ready", 16'(In_Ready), 16'd1);
    exp_q.delete();
    exp_psr = 4'h0;
    @(negedge Clock);
    Reset = 1'b0;
    drive(1'b1, 8'hD5, 3'd5, 1'b1, 4'b0001, 1'b1, 1'b0, 3'd4);
    for (int i = 0; i < 40; i++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 1'b0, 3'($urandom_range(0, 7)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
